// File: rtl/bsg_serial_in_parallel_out_assembler.sv
// Serial-in/parallel-out frame assembler: gathers els_p width_p-bit words into one frame.
// Optional flush of partial frames when BSG_SIPO_FLUSH_EN is defined (adds flush_i, len_o).
module bsg_serial_in_parallel_out_assembler #(
  parameter int width_p        = -1,
  parameter int els_p          = -1,
  parameter int msb_then_lsb_p = 0
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              valid_i,
  input  logic [width_p-1:0]                data_i,
  output logic                              ready_o,
  output logic                              valid_o,
  output logic [els_p-1:0][width_p-1:0]     data_o,
`ifdef BSG_SIPO_FLUSH_EN
  input  logic                              flush_i,
  output logic [$clog2(els_p+1)-1:0]        len_o,
`endif
  input  logic                              yumi_i
);

  localparam int slot_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int len_w_lp  = $clog2(els_p + 1);
  localparam logic [slot_w_lp-1:0] init_lp     = slot_w_lp'((msb_then_lsb_p != 0) ? els_p - 1 : 0);
  localparam logic [slot_w_lp-1:0] end_lp      = slot_w_lp'((msb_then_lsb_p != 0) ? 0 : els_p - 1);
  localparam logic [slot_w_lp-1:0] init_adv_lp = slot_w_lp'((msb_then_lsb_p != 0) ? els_p - 2 : 1);

  typedef enum logic {eFILL, eFULL} state_e;

  state_e                            state_r, state_n;
  logic [slot_w_lp-1:0]              slot_r, slot_n, slot_step;
  logic [els_p-1:0][width_p-1:0]     data_r;
  logic [els_p-1:0]                  we, clr;
  logic                              accept;

  // ready is gated by reset so nothing is offered while the link is held in reset
  assign ready_o   = reset_n_i & ((state_r == eFILL) | ((state_r == eFULL) & yumi_i));
  assign valid_o   = (state_r == eFULL);
  assign accept    = ready_o & valid_i;
  assign data_o    = data_r;
  assign slot_step = (msb_then_lsb_p != 0) ? slot_r - slot_w_lp'(1) : slot_r + slot_w_lp'(1);

`ifdef BSG_SIPO_FLUSH_EN
  logic [len_w_lp-1:0] len_r, len_n, held, held_c;
  logic                flush_go;

  // words already held in the current frame, then including this cycle's accept
  assign held   = (msb_then_lsb_p != 0) ? len_w_lp'(els_p - 1) - len_w_lp'(slot_r)
                                        : len_w_lp'(slot_r);
  assign held_c = held + len_w_lp'(accept);
  assign len_o  = len_r;
`endif

  always_comb begin
    state_n = state_r;
    slot_n  = slot_r;
`ifdef BSG_SIPO_FLUSH_EN
    len_n    = len_r;
    flush_go = 1'b0;
`endif
    case (state_r)
      eFILL: begin
        if (accept) begin
          if (slot_r == end_lp) begin
            state_n = eFULL;
            slot_n  = init_lp;
`ifdef BSG_SIPO_FLUSH_EN
            len_n   = len_w_lp'(els_p);
`endif
          end else begin
            slot_n = slot_step;
          end
        end
`ifdef BSG_SIPO_FLUSH_EN
        if (flush_i && (held_c != '0) && (state_n == eFILL)) begin
          flush_go = 1'b1;
          state_n  = eFULL;
          slot_n   = init_lp;
          len_n    = held_c;
        end
`endif
      end
      eFULL: begin
        if (yumi_i) begin
          // a one-word frame refilled in the drain cycle is immediately full again
          if (!(accept && (els_p == 1))) begin
            state_n = eFILL;
            slot_n  = accept ? init_adv_lp : init_lp;
`ifdef BSG_SIPO_FLUSH_EN
            len_n   = '0;
`endif
          end
        end
      end
      default: state_n = eFILL;
    endcase
  end

  for (genvar i = 0; i < els_p; i++) begin : g_slot
    assign we[i] = accept & (slot_r == slot_w_lp'(i));
`ifdef BSG_SIPO_FLUSH_EN
    // slots past the last held word are zeroed when a partial frame is flushed
    assign clr[i] = flush_go & ((msb_then_lsb_p != 0) ? (len_w_lp'(els_p - i) > held_c)
                                                      : (len_w_lp'(i) >= held_c));
`else
    assign clr[i] = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eFILL;
      slot_r  <= init_lp;
    end else begin
      state_r <= state_n;
      slot_r  <= slot_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (we[i])       data_r[i] <= data_i;
        else if (clr[i]) data_r[i] <= '0;
      end
    end
  end

`ifdef BSG_SIPO_FLUSH_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) len_r <= '0;
    else            len_r <= len_n;
  end
`endif

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_assembler.sv
// Directed bench: ascending/descending 4-word frames, 1-word frames, async reset, optional flush.
module tb_bsg_serial_in_parallel_out_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // main instance: 8b x 4, ascending
  logic            m_v = 0, m_y = 0, m_ready, m_vo;
  logic [7:0]      m_d = 0;
  logic [3:0][7:0] m_dout;
  // descending instance
  logic            d_v = 0, d_y = 0, d_ready, d_vo;
  logic [7:0]      d_d = 0;
  logic [3:0][7:0] d_dout;
  // single-word instance
  logic            s_v = 0, s_y = 0, s_ready, s_vo;
  logic [7:0]      s_d = 0;
  logic [0:0][7:0] s_dout;

`ifdef BSG_SIPO_FLUSH_EN
  logic       m_fl = 0, d_fl = 0, s_fl = 0;
  logic [2:0] m_len, d_len;
  logic [0:0] s_len;
`endif
  logic [2:0] m_elen = 3'd4;

  bsg_serial_in_parallel_out_assembler #(.width_p(8), .els_p(4), .msb_then_lsb_p(0)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .valid_i(m_v), .data_i(m_d), .ready_o(m_ready),
    .valid_o(m_vo), .data_o(m_dout),
`ifdef BSG_SIPO_FLUSH_EN
    .flush_i(m_fl), .len_o(m_len),
`endif
    .yumi_i(m_y));

  bsg_serial_in_parallel_out_assembler #(.width_p(8), .els_p(4), .msb_then_lsb_p(1)) dut_d (
    .clk_i(clk), .reset_n_i(rst_n), .valid_i(d_v), .data_i(d_d), .ready_o(d_ready),
    .valid_o(d_vo), .data_o(d_dout),
`ifdef BSG_SIPO_FLUSH_EN
    .flush_i(d_fl), .len_o(d_len),
`endif
    .yumi_i(d_y));

  bsg_serial_in_parallel_out_assembler #(.width_p(8), .els_p(1), .msb_then_lsb_p(0)) dut_s (
    .clk_i(clk), .reset_n_i(rst_n), .valid_i(s_v), .data_i(s_d), .ready_o(s_ready),
    .valid_o(s_vo), .data_o(s_dout),
`ifdef BSG_SIPO_FLUSH_EN
    .flush_i(s_fl), .len_o(s_len),
`endif
    .yumi_i(s_y));

  // consumer protocol: yumi only while a frame is presented
  always @(posedge clk) begin
    if (rst_n && m_y) chk("m_yumi_legal", m_vo, 1'b1);
    if (rst_n && d_y) chk("d_yumi_legal", d_vo, 1'b1);
    if (rst_n && s_y) chk("s_yumi_legal", s_vo, 1'b1);
  end

  // one cycle on the main instance: drive, check at negedge, advance past next posedge
  task automatic mcyc(input string tag, input logic v, input logic [7:0] d, input logic y,
                      input logic er, input logic ev, input logic [31:0] ed);
    m_v = v; m_d = d; m_y = y;
    @(negedge clk);
    chk({tag, "_rdy"}, m_ready, er);
    chk({tag, "_vld"}, m_vo, ev);
    if (ev) chk({tag, "_dat"}, m_dout, ed);
`ifdef BSG_SIPO_FLUSH_EN
    chk({tag, "_len"}, m_len, ev ? m_elen : 3'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic dcyc(input string tag, input logic v, input logic [7:0] d,
                      input logic er, input logic ev, input logic [31:0] ed);
    d_v = v; d_d = d; d_y = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy"}, d_ready, er);
    chk({tag, "_vld"}, d_vo, ev);
    if (ev) chk({tag, "_dat"}, d_dout, ed);
    @(posedge clk); #1;
  endtask

  task automatic scyc(input string tag, input logic v, input logic [7:0] d, input logic y,
                      input logic ev, input logic [7:0] ed);
    s_v = v; s_d = d; s_y = y;
    @(negedge clk);
    chk({tag, "_rdy"}, s_ready, 1'b1);
    chk({tag, "_vld"}, s_vo, ev);
    if (ev) chk({tag, "_dat"}, s_dout, ed);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", m_ready, 1'b0);
    chk("rst_vld", m_vo, 1'b0);
    chk("rst_dat", m_dout, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic fill
    mcyc("b0", 1, 8'h11, 0, 1, 0, 0);
    mcyc("b1", 1, 8'h22, 0, 1, 0, 0);
    mcyc("b2", 1, 8'h33, 0, 1, 0, 0);
    mcyc("b3", 1, 8'h44, 0, 1, 0, 0);
    mcyc("b4", 0, 8'h00, 1, 1, 1, 32'h44332211);
    mcyc("b5", 0, 8'h00, 0, 1, 0, 0);

    // backpressure with B1 waiting
    mcyc("p0", 1, 8'hA1, 0, 1, 0, 0);
    mcyc("p1", 1, 8'hA2, 0, 1, 0, 0);
    mcyc("p2", 1, 8'hA3, 0, 1, 0, 0);
    mcyc("p3", 1, 8'hA4, 0, 1, 0, 0);
    mcyc("p4", 1, 8'hB1, 0, 0, 1, 32'hA4A3A2A1);
    mcyc("p5", 1, 8'hB1, 0, 0, 1, 32'hA4A3A2A1);
    mcyc("p6", 1, 8'hB1, 0, 0, 1, 32'hA4A3A2A1);
    mcyc("p7", 1, 8'hB1, 1, 1, 1, 32'hA4A3A2A1);
    mcyc("p8", 1, 8'hB2, 0, 1, 0, 0);
    mcyc("p9", 1, 8'hB3, 0, 1, 0, 0);
    mcyc("p10", 1, 8'hB4, 0, 1, 0, 0);
    mcyc("p11", 0, 8'h00, 1, 1, 1, 32'hB4B3B2B1);
    mcyc("p12", 0, 8'h00, 0, 1, 0, 0);

    // descending order; frame left held to be discarded by reset later
    dcyc("d0", 1, 8'h11, 1, 0, 0);
    dcyc("d1", 1, 8'h22, 1, 0, 0);
    dcyc("d2", 1, 8'h33, 1, 0, 0);
    dcyc("d3", 1, 8'h44, 1, 0, 0);
    dcyc("d4", 0, 8'h00, 0, 1, 32'h11223344);
    dcyc("d5", 0, 8'h00, 0, 1, 32'h11223344);

    // single-word frames
    scyc("s0", 1, 8'h05, 0, 0, 0);
    scyc("s1", 1, 8'h06, 1, 1, 8'h05);
    scyc("s2", 1, 8'h07, 1, 1, 8'h06);
    scyc("s3", 0, 8'h00, 1, 1, 8'h07);
    scyc("s4", 0, 8'h00, 0, 0, 0);

    // reset mid-frame, asserted between edges
    mcyc("r0", 1, 8'h11, 0, 1, 0, 0);
    mcyc("r1", 1, 8'h22, 0, 1, 0, 0);
    m_v = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rdy", m_ready, 1'b0);
    chk("mrst_vld", m_vo, 1'b0);
    chk("mrst_dat", m_dout, 32'h0);
    chk("mrst_dvld", d_vo, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mcyc("r2", 1, 8'h0A, 0, 1, 0, 0);
    mcyc("r3", 1, 8'h0B, 0, 1, 0, 0);
    mcyc("r4", 1, 8'h0C, 0, 1, 0, 0);
    mcyc("r5", 1, 8'h0D, 0, 1, 0, 0);
    mcyc("r6", 0, 8'h00, 1, 1, 1, 32'h0D0C0B0A);
    mcyc("r7", 0, 8'h00, 0, 1, 0, 0);

`ifdef BSG_SIPO_FLUSH_EN
    // partial-frame flush, then flush with nothing held
    mcyc("f0", 1, 8'h11, 0, 1, 0, 0);
    mcyc("f1", 1, 8'h22, 0, 1, 0, 0);
    m_fl = 1'b1;
    mcyc("f2", 1, 8'h33, 0, 1, 0, 0);
    m_fl = 1'b0;
    m_elen = 3'd3;
    mcyc("f3", 0, 8'h00, 1, 1, 1, 32'h00332211);
    m_fl = 1'b1;
    mcyc("f4", 0, 8'h00, 0, 1, 0, 0);
    m_fl = 1'b0;
    mcyc("f5", 0, 8'h00, 0, 1, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
